// File: rtl/fog_intensity_lut_pkg.sv
// Shared definitions for the fog intensity LUT: table entry layout, intensity constants,
// loader state encoding and the small arithmetic helpers used by the evaluation pipeline.
package fog_intensity_lut_pkg;

  localparam int ENTRY_WIDTH = 32;
  localparam int BASE_WIDTH  = 16;
  localparam int SLOPE_WIDTH = 16;
  localparam int BASE_MSB    = 31;
  localparam int BASE_LSB    = 16;
  localparam int SLOPE_MSB   = 15;
  localparam int SLOPE_LSB   = 0;
  localparam int SUM_WIDTH   = 18;

  localparam logic [15:0] FOG_INTENSITY_ONE = 16'hFFFF;

  typedef enum logic [0:0] {
    LOADER_IDLE = 1'b0,
    LOADER_LOAD = 1'b1
  } loader_state_t;

  function automatic logic [BASE_WIDTH-1:0] entry_base(input logic [ENTRY_WIDTH-1:0] entry);
    return entry[BASE_MSB:BASE_LSB];
  endfunction

  function automatic logic signed [SLOPE_WIDTH-1:0] entry_slope(input logic [ENTRY_WIDTH-1:0] entry);
    return $signed(entry[SLOPE_MSB:SLOPE_LSB]);
  endfunction

  // Saturate the signed segment sum into the unsigned 16-bit intensity range.
  function automatic logic [15:0] clamp_intensity(input logic signed [SUM_WIDTH-1:0] sum);
    logic [15:0] result;
    if (sum < 18'sd0) begin
      result = 16'h0000;
    end else if (sum > 18'sh0FFFF) begin
      result = FOG_INTENSITY_ONE;
    end else begin
      result = sum[15:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/fog_lut_ram.sv
// Simple dual-port table RAM: one write port, one registered read port with enable.
// Read-first on address collision; contents are never reset.
module fog_lut_ram
  import fog_intensity_lut_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = ENTRY_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; a same-cycle write is not yet visible, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fog_intensity_lut.sv
// Depth-to-fog-intensity converter: stream-loaded piecewise-linear table evaluated in a
// three-stage ce-gated pipeline, with an independent table loader.
module fog_intensity_lut
  import fog_intensity_lut_pkg::*;
#(
  parameter int DEPTH_WIDTH = 24,
  parameter int LUT_LOG2    = 5,
  parameter int FRAC_WIDTH  = 8
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   fogEnable,
  input  logic [DEPTH_WIDTH-1:0] depth,
  output logic [15:0]            intensity,
  input  logic                   s_lut_tvalid,
  output logic                   s_lut_tready,
  input  logic                   s_lut_tlast,
  input  logic [ENTRY_WIDTH-1:0] s_lut_tdata,
  output logic                   lut_busy
);

  localparam int PROD_WIDTH = SLOPE_WIDTH + FRAC_WIDTH + 1;
  localparam int LOW_BITS   = DEPTH_WIDTH - LUT_LOG2 - FRAC_WIDTH;

  loader_state_t            state, state_next;
  logic [LUT_LOG2-1:0]      wr_ptr, wr_ptr_next;
  logic                     ram_we;
  logic [LUT_LOG2-1:0]      ram_waddr;
  logic [ENTRY_WIDTH-1:0]   ram_rdata;

  logic [LUT_LOG2-1:0]      idx;
  logic [FRAC_WIDTH-1:0]    frac;
  logic                     unused_depth;

  logic [FRAC_WIDTH-1:0]    frac_d1;
  logic                     en_d1;
  logic signed [PROD_WIDTH-1:0] prod_d2;
  logic [BASE_WIDTH-1:0]    base_d2;
  logic                     en_d2;

  logic signed [PROD_WIDTH-1:0] slope_ext;
  logic signed [PROD_WIDTH-1:0] frac_ext;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [PROD_WIDTH-1:0] base_ext;
  logic signed [SUM_WIDTH-1:0]  sum;

  assign idx          = depth[DEPTH_WIDTH-1 -: LUT_LOG2];
  assign frac         = depth[DEPTH_WIDTH-LUT_LOG2-1 -: FRAC_WIDTH];
  assign unused_depth = ^depth[LOW_BITS-1:0];
  assign s_lut_tready = 1'b1;

  fog_lut_ram #(
    .ADDR_WIDTH (LUT_LOG2),
    .DATA_WIDTH (ENTRY_WIDTH)
  ) u_ram (
    .clk   (aclk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (s_lut_tdata),
    .re    (ce),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  // Loader next-state: every valid beat is written; tlast always returns to IDLE with the pointer at 0.
  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr;
    case (state)
      LOADER_IDLE: begin
        if (s_lut_tvalid) begin
          ram_we    = 1'b1;
          ram_waddr = {LUT_LOG2{1'b0}};
          if (s_lut_tlast) begin
            wr_ptr_next = {LUT_LOG2{1'b0}};
            state_next  = LOADER_IDLE;
          end else begin
            wr_ptr_next = LUT_LOG2'(1);
            state_next  = LOADER_LOAD;
          end
        end else begin
          state_next = LOADER_IDLE;
        end
      end
      LOADER_LOAD: begin
        if (s_lut_tvalid) begin
          ram_we = 1'b1;
          if (s_lut_tlast) begin
            wr_ptr_next = {LUT_LOG2{1'b0}};
            state_next  = LOADER_IDLE;
          end else begin
            wr_ptr_next = wr_ptr + LUT_LOG2'(1);
            state_next  = LOADER_LOAD;
          end
        end else begin
          state_next = LOADER_LOAD;
        end
      end
      default: begin
        state_next  = LOADER_IDLE;
        wr_ptr_next = {LUT_LOG2{1'b0}};
      end
    endcase
  end

  // Loader state, write pointer and busy flag.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state    <= LOADER_IDLE;
      wr_ptr   <= {LUT_LOG2{1'b0}};
      lut_busy <= 1'b0;
    end else begin
      state    <= state_next;
      wr_ptr   <= wr_ptr_next;
      lut_busy <= (state_next == LOADER_LOAD);
    end
  end

  // Segment interpolation: slope times unsigned fraction, then base plus the scaled product.
  always_comb begin
    slope_ext = {{(PROD_WIDTH-SLOPE_WIDTH){ram_rdata[SLOPE_MSB]}}, entry_slope(ram_rdata)};
    frac_ext  = {{(PROD_WIDTH-FRAC_WIDTH){1'b0}}, frac_d1};
    prod      = slope_ext * frac_ext;
    base_ext  = $signed({{(PROD_WIDTH-BASE_WIDTH){1'b0}}, base_d2});
    sum       = SUM_WIDTH'(base_ext + (prod_d2 >>> FRAC_WIDTH));
  end

  // Evaluation pipeline; every stage holds while ce is low.
  always_ff @(posedge aclk) begin
    if (reset) begin
      frac_d1   <= {FRAC_WIDTH{1'b0}};
      en_d1     <= 1'b0;
      prod_d2   <= {PROD_WIDTH{1'b0}};
      base_d2   <= {BASE_WIDTH{1'b0}};
      en_d2     <= 1'b0;
      intensity <= FOG_INTENSITY_ONE;
    end else if (ce) begin
      frac_d1   <= frac;
      en_d1     <= fogEnable;
      prod_d2   <= prod;
      base_d2   <= entry_base(ram_rdata);
      en_d2     <= en_d1;
      intensity <= en_d2 ? clamp_intensity(sum) : FOG_INTENSITY_ONE;
    end
  end

endmodule

// File: tb/tb_fog_intensity_lut.sv
// Scoreboard bench for fog_intensity_lut: a table model tracks loads, expected intensities are
// queued as depths are issued and popped as results leave the pipeline.
module tb_fog_intensity_lut;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        fog_enable = 1'b0;
  logic [23:0] depth = 24'h000000;
  logic [15:0] intensity;
  logic        s_lut_tvalid = 1'b0;
  logic        s_lut_tready;
  logic        s_lut_tlast = 1'b0;
  logic [31:0] s_lut_tdata = 32'h0;
  logic        lut_busy;

  logic [31:0] lut_model [0:31];
  int          ptr_m = 0;
  bit          loading_m = 1'b0;
  logic [15:0] exp_q [$];
  logic [15:0] last_exp = 16'hFFFF;
  int          checks = 0;
  int          errors = 0;

  fog_intensity_lut dut (
    .aclk         (aclk),
    .reset        (reset),
    .ce           (ce),
    .fogEnable    (fog_enable),
    .depth        (depth),
    .intensity    (intensity),
    .s_lut_tvalid (s_lut_tvalid),
    .s_lut_tready (s_lut_tready),
    .s_lut_tlast  (s_lut_tlast),
    .s_lut_tdata  (s_lut_tdata),
    .lut_busy     (lut_busy)
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_eval(input bit en, input logic [23:0] d);
    logic [31:0] e;
    int b, s, f, p, sum;
    if (!en) return 16'hFFFF;
    e   = lut_model[d[23:19]];
    b   = int'(e[31:16]);
    s   = int'($signed(e[15:0]));
    f   = int'(d[18:11]);
    p   = s * f;
    sum = b + (p >>> 8);
    if (sum < 0) return 16'h0000;
    if (sum > 65535) return 16'hFFFF;
    return sum[15:0];
  endfunction

  task automatic tick();
    logic [15:0] e;
    if (ce) exp_q.push_back(model_eval(fog_enable, depth));
    @(posedge aclk);
    #1;
    if (ce) begin
      if (exp_q.size() == 0) begin
        check_val("queue_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("intensity", {16'h0, intensity}, {16'h0, e});
        last_exp = e;
      end
    end else begin
      check_val("hold", {16'h0, intensity}, {16'h0, last_exp});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce = 1'b1;
    fog_enable = 1'b1;
    s_lut_tvalid = 1'b0;
    s_lut_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      depth = 24'($urandom);
      @(posedge aclk);
      #1;
      check_val("rst_intensity", {16'h0, intensity}, 32'h0000FFFF);
      check_val("rst_busy", {31'h0, lut_busy}, 32'h0);
      check_val("rst_tready", {31'h0, s_lut_tready}, 32'h1);
    end
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'hFFFF);
    last_exp = 16'hFFFF;
    ptr_m = 0;
    loading_m = 1'b0;
  endtask

  task automatic load_beat(input logic [31:0] d, input bit last);
    ce = 1'b0;
    s_lut_tvalid = 1'b1;
    s_lut_tdata = d;
    s_lut_tlast = last;
    check_val("busy", {31'h0, lut_busy}, {31'h0, loading_m});
    check_val("tready", {31'h0, s_lut_tready}, 32'h1);
    tick();
    lut_model[ptr_m] = d;
    if (last) begin
      ptr_m = 0;
      loading_m = 1'b0;
    end else begin
      ptr_m = (ptr_m + 1) % 32;
      loading_m = 1'b1;
    end
    s_lut_tvalid = 1'b0;
    s_lut_tlast = 1'b0;
  endtask

  task automatic eval(input bit en, input logic [23:0] d);
    ce = 1'b1;
    fog_enable = en;
    depth = d;
    tick();
  endtask

  task automatic hold_tick(input logic [23:0] junk);
    ce = 1'b0;
    fog_enable = 1'b1;
    depth = junk;
    tick();
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) eval(1'b0, 24'h0);
  endtask

  task automatic sweep_entries();
    for (int i = 0; i < 32; i++) eval(1'b1, {5'(i), 8'h00, 11'h000});
    for (int i = 0; i < 32; i++) eval(1'b1, {5'(i), 8'($urandom), 11'($urandom)});
    flush();
  endtask

  initial begin
    // 1: reset and fog disabled
    do_reset();
    for (int i = 0; i < 5; i++) eval(1'b0, 24'($urandom));

    // 2: ramp table and the reference interpolation point
    for (int i = 0; i < 32; i++) load_beat({16'(i * 16'h0800), 16'h0800}, i == 31);
    check_val("busy_after_load", {31'h0, lut_busy}, 32'h0);
    eval(1'b1, 24'h0C8000);
    eval(1'b0, 24'h0);
    eval(1'b0, 24'h0);
    check_val("ramp_point", {16'h0, intensity}, 32'h00000C80);
    flush();

    // 3: clamping at both ends, low depth bits ignored
    for (int i = 0; i < 32; i++) begin
      if (i == 5) load_beat({16'hFF00, 16'h7FFF}, 1'b0);
      else if (i == 6) load_beat({16'h0010, 16'h8000}, 1'b0);
      else load_beat({16'(i * 16'h0400), 16'($urandom)}, i == 31);
    end
    eval(1'b1, {5'd5, 8'hFF, 11'h7FF});
    eval(1'b1, {5'd6, 8'h80, 11'h123});
    eval(1'b0, 24'h0);
    check_val("clamp_high", {16'h0, intensity}, 32'h0000FFFF);
    eval(1'b0, 24'h0);
    check_val("clamp_low", {16'h0, intensity}, 32'h00000000);
    flush();

    // 4: ce pattern 1,0,0,1 across a four-depth stream
    eval(1'b1, {5'd3, 8'h40, 11'h0});
    hold_tick(24'hFFFFFF);
    hold_tick(24'h123456);
    eval(1'b1, {5'd9, 8'hC0, 11'h0});
    eval(1'b1, {5'd31, 8'hFF, 11'h0});
    hold_tick(24'h000000);
    eval(1'b1, {5'd0, 8'h01, 11'h0});
    flush();
    hold_tick(24'hABCDEF);

    // 5: partial load keeps old entries; 33 beats wrap onto entry 0
    for (int i = 0; i < 32; i++) load_beat({16'(16'h0100 + i), 16'($urandom)}, i == 31);
    for (int i = 0; i < 4; i++) load_beat({16'(16'hA000 + i), 16'h0010}, i == 3);
    check_val("partial_idle", {31'h0, lut_busy}, 32'h0);
    sweep_entries();
    load_beat(32'h5555_0000, 1'b1);
    sweep_entries();
    for (int i = 0; i < 33; i++) load_beat({16'(16'h2000 + i * 16'h0100), 16'($urandom)}, 1'b0);
    check_val("wrap_busy", {31'h0, lut_busy}, 32'h1);
    sweep_entries();
    load_beat(32'h7777_1111, 1'b1);
    check_val("wrap_end_idle", {31'h0, lut_busy}, 32'h0);
    sweep_entries();

    // 6: reset mid-load, then a fresh full load and random evaluation
    for (int i = 0; i < 10; i++) load_beat({16'(16'h3000 + i), 16'h0100}, 1'b0);
    do_reset();
    for (int i = 0; i < 32; i++) load_beat($urandom, i == 31);
    sweep_entries();
    for (int i = 0; i < 40; i++) begin
      if (($urandom % 4) == 0) hold_tick(24'($urandom));
      else eval(1'($urandom), 24'($urandom));
    end
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
